// File: rtl/cpu_pkg.sv
// Shared CPU constants and enumerations for the fetch stage.
package cpu_pkg;

   localparam logic [31:0] RESET_VEC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO   = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI   = 32'h0000_4FFC;

   // Next-PC source selection
   typedef enum logic [2:0] {
      SEQ   = 3'd0,
      REDIR = 3'd1,
      ERET  = 3'd2,
      EXC   = 3'd3,
      HOLD  = 3'd4
   } npc_sel_t;

   // Fetch-fault capture state
   typedef enum logic {
      IDLE     = 1'b0,
      CAPTURED = 1'b1
   } flt_state_t;

endpackage

// File: rtl/pc_fault_check.sv
// Combinational fetch-address legality check: word alignment plus the
// inclusive [LO, HI] instruction-memory window (unsigned compare).
module pc_fault_check import cpu_pkg::*; #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] LO    = WIDTH'(cpu_pkg::IMEM_LO),
   parameter logic [WIDTH-1:0] HI    = WIDTH'(cpu_pkg::IMEM_HI)
) (
   input  logic [WIDTH-1:0] addr,
   output logic             fault
);

   // Flag misaligned or out-of-window addresses
   always_comb begin
      fault = (addr[1:0] != 2'b00) || (addr < LO) || (addr > HI);
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC selection (sequential, redirect,
// ERET, exception vector), fetch-fault capture and fetched-cycle counter.
module pc_unit import cpu_pkg::*; #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(cpu_pkg::RESET_VEC),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(cpu_pkg::EXC_VEC),
   parameter logic [WIDTH-1:0] IMEM_LO   = WIDTH'(cpu_pkg::IMEM_LO),
   parameter logic [WIDTH-1:0] IMEM_HI   = WIDTH'(cpu_pkg::IMEM_HI),
   parameter int               CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             exc_req,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   input  logic             fault_ack,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             fetch_fault,
   output logic [WIDTH-1:0] bad_pc,
   output logic [CNT_W-1:0] fetch_cnt
);

   npc_sel_t         npc_sel;
   logic [WIDTH-1:0] pc_d, pc_q;
   logic             fault_d, fault_q;
   logic [WIDTH-1:0] bad_pc_d, bad_pc_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   flt_state_t       state_d, state_q;

   assign pc_plus4 = pc_q + WIDTH'(32'd4);

   // Next-PC source priority: exception beats ERET, stall beats redirect
   always_comb begin
      npc_sel = SEQ;
      if (exc_req) begin
         npc_sel = EXC;
      end else if (en && eret) begin
         npc_sel = ERET;
      end else if (!en) begin
         npc_sel = HOLD;
      end else if (redirect) begin
         npc_sel = REDIR;
      end else begin
         npc_sel = SEQ;
      end
   end

   // Next-PC mux and fetch counter update
   always_comb begin
      pc_d = pc_q;
      case (npc_sel)
         SEQ:     pc_d = pc_plus4;
         REDIR:   pc_d = redirect_pc;
         ERET:    pc_d = epc;
         EXC:     pc_d = EXC_VEC;
         HOLD:    pc_d = pc_q;
         default: pc_d = pc_q;
      endcase
      if (npc_sel != HOLD) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Fault flag travels with the PC it describes
   pc_fault_check #(
      .WIDTH (WIDTH),
      .LO    (IMEM_LO),
      .HI    (IMEM_HI)
   ) u_fault_check (
      .addr  (pc_d),
      .fault (fault_d)
   );

   // Fault capture FSM: latch the first faulting pc until CP0 acks it
   always_comb begin
      state_d  = state_q;
      bad_pc_d = bad_pc_q;
      case (state_q)
         IDLE: begin
            if (fault_q) begin
               state_d  = CAPTURED;
               bad_pc_d = pc_q;
            end else begin
               state_d  = IDLE;
            end
         end
         CAPTURED: begin
            if (fault_ack) begin
               state_d = IDLE;
            end else begin
               state_d = CAPTURED;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q     <= RESET_VEC;
         fault_q  <= 1'b0;
         bad_pc_q <= '0;
         cnt_q    <= '0;
         state_q  <= IDLE;
      end else begin
         pc_q     <= pc_d;
         fault_q  <= fault_d;
         bad_pc_q <= bad_pc_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
      end
   end

   assign pc          = pc_q;
   assign fetch_fault = fault_q;
   assign bad_pc      = bad_pc_q;
   assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a 32-bit instance for the main scenarios
// and a 16-bit instance for the address wrap-around case.
module tb_pc_unit;

   typedef struct packed {
      logic        rst_n;
      logic        en;
      logic        redir;
      logic [31:0] rpc;
      logic        eret;
      logic [31:0] epc;
      logic        exc;
      logic        ack;
   } stim_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        fault;
      logic [31:0] bad;
      logic [31:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance signals
   logic        reset, en, redirect, exc_req, eret, fault_ack;
   logic [31:0] redirect_pc, epc;
   logic [31:0] pc, pc_plus4, bad_pc, fetch_cnt;
   logic        fetch_fault;

   // 16-bit instance signals
   logic        reset16, en16, redirect16, exc_req16, eret16, fault_ack16;
   logic [15:0] redirect_pc16, epc16;
   logic [15:0] pc16, pc_plus4_16, bad_pc16, fetch_cnt16;
   logic        fetch_fault16;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   pc_unit dut32 (
      .clk(clk), .reset(reset), .en(en), .redirect(redirect),
      .redirect_pc(redirect_pc), .exc_req(exc_req), .eret(eret), .epc(epc),
      .fault_ack(fault_ack), .pc(pc), .pc_plus4(pc_plus4),
      .fetch_fault(fetch_fault), .bad_pc(bad_pc), .fetch_cnt(fetch_cnt)
   );

   pc_unit #(
      .WIDTH(16), .RESET_VEC(16'h3000), .EXC_VEC(16'h4180),
      .IMEM_LO(16'h3000), .IMEM_HI(16'hFFFC), .CNT_W(16)
   ) dut16 (
      .clk(clk), .reset(reset16), .en(en16), .redirect(redirect16),
      .redirect_pc(redirect_pc16), .exc_req(exc_req16), .eret(eret16), .epc(epc16),
      .fault_ack(fault_ack16), .pc(pc16), .pc_plus4(pc_plus4_16),
      .fetch_fault(fetch_fault16), .bad_pc(bad_pc16), .fetch_cnt(fetch_cnt16)
   );

   function automatic stim_t mk_s(logic r, logic e, logic rd, logic [31:0] rp,
                                  logic er, logic [31:0] ep, logic ex, logic ak);
      stim_t s;
      s.rst_n = r; s.en = e; s.redir = rd; s.rpc = rp;
      s.eret = er; s.epc = ep; s.exc = ex; s.ack = ak;
      return s;
   endfunction

   function automatic exp_t mk_e(logic [31:0] p, logic f, logic [31:0] b, logic [31:0] c);
      exp_t x;
      x.pc = p; x.fault = f; x.bad = b; x.cnt = c;
      return x;
   endfunction

   task automatic apply32(input stim_t s);
      reset = s.rst_n; en = s.en; redirect = s.redir; redirect_pc = s.rpc;
      eret = s.eret; epc = s.epc; exc_req = s.exc; fault_ack = s.ack;
   endtask

   task automatic apply16(input stim_t s);
      reset16 = s.rst_n; en16 = s.en; redirect16 = s.redir; redirect_pc16 = s.rpc[15:0];
      eret16 = s.eret; epc16 = s.epc[15:0]; exc_req16 = s.exc; fault_ack16 = s.ack;
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t s[5]; exp_t x[5]; exp_t e;
      s[0] = mk_s(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0); x[0] = mk_e(32'h3000, 1'b0, 32'h0, 32'd0);
      s[1] = mk_s(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0); x[1] = mk_e(32'h3000, 1'b0, 32'h0, 32'd0);
      s[2] = mk_s(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0); x[2] = mk_e(32'h3004, 1'b0, 32'h0, 32'd1);
      s[3] = mk_s(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0); x[3] = mk_e(32'h3008, 1'b0, 32'h0, 32'd2);
      s[4] = mk_s(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0); x[4] = mk_e(32'h300C, 1'b0, 32'h0, 32'd3);
      for (int i = 0; i < 5; i++) begin
         apply32(s[i]); exp_q.push_back(x[i]); clk_step();
         e = exp_q.pop_front(); n_cmp++;
         if ({pc, pc_plus4, fetch_fault, bad_pc, fetch_cnt} !== {e.pc, e.pc + 32'd4, e.fault, e.bad, e.cnt}) begin
            n_bad++;
            $display("FAIL reset[%0d]: got pc=%h p4=%h flt=%b bad=%h cnt=%0d, want pc=%h flt=%b bad=%h cnt=%0d",
                     i, pc, pc_plus4, fetch_fault, bad_pc, fetch_cnt, e.pc, e.fault, e.bad, e.cnt);
         end
      end
   endtask

   task automatic test_stall();
      stim_t s[5]; exp_t x[5]; exp_t e;
      s[0] = mk_s(1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0); x[0] = mk_e(32'h3010, 1'b0, 32'h0, 32'd4);
      s[1] = mk_s(1'b1, 1'b0, 1'b1, 32'h3100, 1'b0, 32'h0,    1'b0, 1'b0); x[1] = mk_e(32'h3010, 1'b0, 32'h0, 32'd4);
      s[2] = mk_s(1'b1, 1'b0, 1'b1, 32'h3100, 1'b0, 32'h0,    1'b0, 1'b0); x[2] = mk_e(32'h3010, 1'b0, 32'h0, 32'd4);
      s[3] = mk_s(1'b1, 1'b0, 1'b1, 32'h3100, 1'b1, 32'h3200, 1'b0, 1'b0); x[3] = mk_e(32'h3010, 1'b0, 32'h0, 32'd4);
      s[4] = mk_s(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0); x[4] = mk_e(32'h3010, 1'b0, 32'h0, 32'd4);
      for (int i = 0; i < 5; i++) begin
         apply32(s[i]); exp_q.push_back(x[i]); clk_step();
         e = exp_q.pop_front(); n_cmp++;
         if ({pc, pc_plus4, fetch_fault, bad_pc, fetch_cnt} !== {e.pc, e.pc + 32'd4, e.fault, e.bad, e.cnt}) begin
            n_bad++;
            $display("FAIL stall[%0d]: got pc=%h p4=%h flt=%b bad=%h cnt=%0d, want pc=%h flt=%b bad=%h cnt=%0d",
                     i, pc, pc_plus4, fetch_fault, bad_pc, fetch_cnt, e.pc, e.fault, e.bad, e.cnt);
         end
      end
   endtask

   task automatic test_priority();
      stim_t s[5]; exp_t x[5]; exp_t e;
      s[0] = mk_s(1'b1, 1'b1, 1'b1, 32'h3100, 1'b1, 32'h3200, 1'b0, 1'b0); x[0] = mk_e(32'h3200, 1'b0, 32'h0, 32'd5);
      s[1] = mk_s(1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3200, 1'b1, 1'b0); x[1] = mk_e(32'h4180, 1'b0, 32'h0, 32'd6);
      s[2] = mk_s(1'b1, 1'b1, 1'b1, 32'h3100, 1'b0, 32'h0,    1'b0, 1'b0); x[2] = mk_e(32'h3100, 1'b0, 32'h0, 32'd7);
      s[3] = mk_s(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0); x[3] = mk_e(32'h4180, 1'b0, 32'h0, 32'd8);
      s[4] = mk_s(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0); x[4] = mk_e(32'h4180, 1'b0, 32'h0, 32'd8);
      for (int i = 0; i < 5; i++) begin
         apply32(s[i]); exp_q.push_back(x[i]); clk_step();
         e = exp_q.pop_front(); n_cmp++;
         if ({pc, pc_plus4, fetch_fault, bad_pc, fetch_cnt} !== {e.pc, e.pc + 32'd4, e.fault, e.bad, e.cnt}) begin
            n_bad++;
            $display("FAIL priority[%0d]: got pc=%h p4=%h flt=%b bad=%h cnt=%0d, want pc=%h flt=%b bad=%h cnt=%0d",
                     i, pc, pc_plus4, fetch_fault, bad_pc, fetch_cnt, e.pc, e.fault, e.bad, e.cnt);
         end
      end
   endtask

   task automatic test_fault();
      stim_t s[9]; exp_t x[9]; exp_t e;
      s[0] = mk_s(1'b1, 1'b1, 1'b1, 32'h3002, 1'b0, 32'h0, 1'b0, 1'b0); x[0] = mk_e(32'h3002, 1'b1, 32'h0,    32'd9);
      s[1] = mk_s(1'b1, 1'b1, 1'b1, 32'h5000, 1'b0, 32'h0, 1'b0, 1'b0); x[1] = mk_e(32'h5000, 1'b1, 32'h3002, 32'd10);
      s[2] = mk_s(1'b1, 1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0, 1'b0); x[2] = mk_e(32'h3100, 1'b0, 32'h3002, 32'd11);
      s[3] = mk_s(1'b1, 1'b1, 1'b1, 32'h2FFC, 1'b0, 32'h0, 1'b0, 1'b1); x[3] = mk_e(32'h2FFC, 1'b1, 32'h3002, 32'd12);
      s[4] = mk_s(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b0); x[4] = mk_e(32'h2FFC, 1'b1, 32'h2FFC, 32'd12);
      s[5] = mk_s(1'b1, 1'b1, 1'b1, 32'h3001, 1'b0, 32'h0, 1'b0, 1'b1); x[5] = mk_e(32'h3001, 1'b1, 32'h2FFC, 32'd13);
      s[6] = mk_s(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b0); x[6] = mk_e(32'h3001, 1'b1, 32'h3001, 32'd13);
      s[7] = mk_s(1'b1, 1'b1, 1'b1, 32'h4FFC, 1'b0, 32'h0, 1'b0, 1'b0); x[7] = mk_e(32'h4FFC, 1'b0, 32'h3001, 32'd14);
      s[8] = mk_s(1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b0); x[8] = mk_e(32'h5000, 1'b1, 32'h3001, 32'd15);
      for (int i = 0; i < 9; i++) begin
         apply32(s[i]); exp_q.push_back(x[i]); clk_step();
         e = exp_q.pop_front(); n_cmp++;
         if ({pc, pc_plus4, fetch_fault, bad_pc, fetch_cnt} !== {e.pc, e.pc + 32'd4, e.fault, e.bad, e.cnt}) begin
            n_bad++;
            $display("FAIL fault[%0d]: got pc=%h p4=%h flt=%b bad=%h cnt=%0d, want pc=%h flt=%b bad=%h cnt=%0d",
                     i, pc, pc_plus4, fetch_fault, bad_pc, fetch_cnt, e.pc, e.fault, e.bad, e.cnt);
         end
      end
   endtask

   task automatic test_wrap16();
      stim_t s[8]; exp_t x[8]; exp_t e;
      logic [15:0] want_p4;
      s[0] = mk_s(1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b0); x[0] = mk_e(32'h3000, 1'b0, 32'h0,    32'd0);
      s[1] = mk_s(1'b1, 1'b1, 1'b1, 32'h3002, 1'b0, 32'h0, 1'b0, 1'b0); x[1] = mk_e(32'h3002, 1'b1, 32'h0,    32'd1);
      s[2] = mk_s(1'b1, 1'b1, 1'b1, 32'hFFFC, 1'b0, 32'h0, 1'b0, 1'b0); x[2] = mk_e(32'hFFFC, 1'b0, 32'h3002, 32'd2);
      s[3] = mk_s(1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b0); x[3] = mk_e(32'h0000, 1'b1, 32'h3002, 32'd3);
      s[4] = mk_s(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b0); x[4] = mk_e(32'h0000, 1'b1, 32'h3002, 32'd3);
      s[5] = mk_s(1'b0, 1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b1, 1'b0); x[5] = mk_e(32'h3000, 1'b0, 32'h0,    32'd0);
      s[6] = mk_s(1'b1, 1'b1, 1'b1, 32'h3006, 1'b0, 32'h0, 1'b0, 1'b0); x[6] = mk_e(32'h3006, 1'b1, 32'h0,    32'd1);
      s[7] = mk_s(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b0); x[7] = mk_e(32'h3006, 1'b1, 32'h3006, 32'd1);
      for (int i = 0; i < 8; i++) begin
         apply16(s[i]); exp_q.push_back(x[i]); clk_step();
         e = exp_q.pop_front(); n_cmp++;
         want_p4 = e.pc[15:0] + 16'd4;
         if ({pc16, pc_plus4_16, fetch_fault16, bad_pc16, fetch_cnt16} !==
             {e.pc[15:0], want_p4, e.fault, e.bad[15:0], e.cnt[15:0]}) begin
            n_bad++;
            $display("FAIL wrap16[%0d]: got pc=%h p4=%h flt=%b bad=%h cnt=%0d, want pc=%h p4=%h flt=%b bad=%h cnt=%0d",
                     i, pc16, pc_plus4_16, fetch_fault16, bad_pc16, fetch_cnt16,
                     e.pc[15:0], want_p4, e.fault, e.bad[15:0], e.cnt[15:0]);
         end
      end
   endtask

   initial begin
      apply32(mk_s(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
      apply16(mk_s(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
      test_reset();
      test_stall();
      test_priority();
      test_fault();
      test_wrap16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
